// File: rtl/vdma_axi4_to_axi4s_core.sv
// Video DMA read core: fetches a frame over AXI4 in per-line bursts and
// forwards the returned beats as an AXI4-Stream with tuser/tlast framing.
module vdma_axi4_to_axi4s_core #(
    parameter int AXI4_ID_WIDTH    = 6,
    parameter int AXI4_ADDR_WIDTH  = 32,
    parameter int AXI4_DATA_SIZE   = 2,
    parameter int AXI4_LEN_WIDTH   = 8,
    parameter int AXI4_QOS_WIDTH   = 4,
    parameter int AXI4S_USER_WIDTH = 1,
    parameter int AXI4S_DATA_WIDTH = 24,
    parameter int STRIDE_WIDTH     = 12,
    parameter int INDEX_WIDTH      = 8,
    parameter int H_WIDTH          = 12,
    parameter int V_WIDTH          = 12,
    localparam int DW              = 8 << AXI4_DATA_SIZE
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        ctl_enable,
    input  logic                        ctl_update,
    output logic                        ctl_busy,
    output logic [INDEX_WIDTH-1:0]      ctl_index,
    input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr,
    input  logic [STRIDE_WIDTH-1:0]     param_stride,
    input  logic [H_WIDTH-1:0]          param_width,
    input  logic [V_WIDTH-1:0]          param_height,
    input  logic [AXI4_LEN_WIDTH-1:0]   param_arlen,
    output logic [AXI4_ADDR_WIDTH-1:0]  monitor_addr,
    output logic [STRIDE_WIDTH-1:0]     monitor_stride,
    output logic [H_WIDTH-1:0]          monitor_width,
    output logic [V_WIDTH-1:0]          monitor_height,
    output logic [AXI4_LEN_WIDTH-1:0]   monitor_arlen,
    output logic [AXI4_ID_WIDTH-1:0]    m_axi4_arid,
    output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_araddr,
    output logic [1:0]                  m_axi4_arburst,
    output logic [3:0]                  m_axi4_arcache,
    output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_arlen,
    output logic [0:0]                  m_axi4_arlock,
    output logic [2:0]                  m_axi4_arprot,
    output logic [AXI4_QOS_WIDTH-1:0]   m_axi4_arqos,
    output logic [3:0]                  m_axi4_arregion,
    output logic [2:0]                  m_axi4_arsize,
    output logic                        m_axi4_arvalid,
    input  logic                        m_axi4_arready,
    input  logic [AXI4_ID_WIDTH-1:0]    m_axi4_rid,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic [DW-1:0]               m_axi4_rdata,
    input  logic                        m_axi4_rlast,
    input  logic                        m_axi4_rvalid,
    output logic                        m_axi4_rready,
    output logic [AXI4S_USER_WIDTH-1:0] m_axi4s_tuser,
    output logic                        m_axi4s_tlast,
    output logic [AXI4S_DATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                        m_axi4s_tvalid,
    input  logic                        m_axi4s_tready
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic                       first_q;
    logic                       ar_done, px_done;
    logic [H_WIDTH-1:0]         ar_x, px_x;
    logic [V_WIDTH-1:0]         ar_y, px_y;
    logic [AXI4_ADDR_WIDTH-1:0] line_addr;

    logic running, start, finish, load, xfer;
    logic [AXI4_ADDR_WIDTH-1:0] sel_addr;
    logic [STRIDE_WIDTH-1:0]    sel_stride;
    logic [H_WIDTH-1:0]         sel_width;
    logic [V_WIDTH-1:0]         sel_height;
    logic [AXI4_LEN_WIDTH-1:0]  sel_arlen;
    logic [31:0]                remain, burst, take;
    logic                       line_end;
    logic                       unused_ok;

    assign m_axi4_arid     = '0;
    assign m_axi4_arburst  = 2'b01;
    assign m_axi4_arcache  = 4'b0011;
    assign m_axi4_arlock   = 1'b0;
    assign m_axi4_arprot   = 3'b000;
    assign m_axi4_arqos    = '0;
    assign m_axi4_arregion = 4'b0000;
    assign m_axi4_arsize   = 3'(AXI4_DATA_SIZE);

    // R is a pure passthrough; response id/resp/last carry no framing here
    assign m_axi4s_tdata  = m_axi4_rdata[AXI4S_DATA_WIDTH-1:0];
    assign m_axi4s_tvalid = m_axi4_rvalid;
    assign m_axi4_rready  = m_axi4s_tready;
    assign unused_ok = ^{m_axi4_rid, m_axi4_rresp, m_axi4_rlast,
                         m_axi4_rdata[DW-1:AXI4S_DATA_WIDTH]};

    assign running  = (state_q == ST_RUN);
    assign ctl_busy = running;
    assign start    = (state_q == ST_IDLE) && ctl_enable;
    assign finish   = running && ar_done && px_done;
    assign load     = ctl_update || first_q;
    assign xfer     = running && !px_done && m_axi4_rvalid && m_axi4s_tready;

    assign sel_addr   = load ? param_addr   : monitor_addr;
    assign sel_stride = load ? param_stride : monitor_stride;
    assign sel_width  = load ? param_width  : monitor_width;
    assign sel_height = load ? param_height : monitor_height;
    assign sel_arlen  = load ? param_arlen  : monitor_arlen;

    assign m_axi4s_tuser = AXI4S_USER_WIDTH'(running && !px_done &&
                                             px_x == '0 && px_y == '0);
    assign m_axi4s_tlast = running && !px_done &&
                           (px_x == monitor_width - H_WIDTH'(1));

    // Burst sizing: a full (arlen+1) burst, or the tail of the line
    assign remain   = 32'(monitor_width) - 32'(ar_x);
    assign burst    = 32'(monitor_arlen) + 32'd1;
    assign take     = (remain < burst) ? remain : burst;
    assign line_end = (remain <= burst);

    always_ff @(posedge aclk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ctl_enable) state_d = ST_RUN;
            ST_RUN:  if (finish)     state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            first_q        <= 1'b1;
            ctl_index      <= '0;
            monitor_addr   <= '0;
            monitor_stride <= '0;
            monitor_width  <= '0;
            monitor_height <= '0;
            monitor_arlen  <= '0;
            m_axi4_arvalid <= 1'b0;
            m_axi4_araddr  <= '0;
            m_axi4_arlen   <= '0;
            ar_x           <= '0;
            ar_y           <= '0;
            line_addr      <= '0;
            ar_done        <= 1'b0;
            px_x           <= '0;
            px_y           <= '0;
            px_done        <= 1'b0;
        end else if (start) begin
            first_q        <= 1'b0;
            ctl_index      <= ctl_index + INDEX_WIDTH'(1);
            monitor_addr   <= sel_addr;
            monitor_stride <= sel_stride;
            monitor_width  <= sel_width;
            monitor_height <= sel_height;
            monitor_arlen  <= sel_arlen;
            m_axi4_arvalid <= 1'b0;
            ar_x           <= '0;
            ar_y           <= '0;
            line_addr      <= sel_addr;
            px_x           <= '0;
            px_y           <= '0;
            // An empty frame is done before it issues anything
            ar_done        <= (sel_width == '0) || (sel_height == '0);
            px_done        <= (sel_width == '0) || (sel_height == '0);
        end else if (running) begin
            if (m_axi4_arvalid) begin
                if (m_axi4_arready) begin
                    m_axi4_arvalid <= 1'b0;
                    if (line_end) begin
                        ar_x      <= '0;
                        line_addr <= line_addr +
                                     AXI4_ADDR_WIDTH'(monitor_stride);
                        if (ar_y == monitor_height - V_WIDTH'(1))
                            ar_done <= 1'b1;
                        else
                            ar_y <= ar_y + V_WIDTH'(1);
                    end else begin
                        ar_x <= ar_x + H_WIDTH'(take);
                    end
                end
            end else if (!ar_done) begin
                m_axi4_arvalid <= 1'b1;
                m_axi4_araddr  <= line_addr +
                    (AXI4_ADDR_WIDTH'(ar_x) << AXI4_DATA_SIZE);
                m_axi4_arlen   <= AXI4_LEN_WIDTH'(take - 32'd1);
            end
            if (xfer) begin
                if (px_x == monitor_width - H_WIDTH'(1)) begin
                    px_x <= '0;
                    if (px_y == monitor_height - V_WIDTH'(1))
                        px_done <= 1'b1;
                    else
                        px_y <= px_y + V_WIDTH'(1);
                end else begin
                    px_x <= px_x + H_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vdma_axi4_to_axi4s_core.sv
// Bench for vdma_axi4_to_axi4s_core: random-latency AXI4 slave and stream
// sink, compared against a frame-level model of bursts and pixels.
module tb_vdma_axi4_to_axi4s_core;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        reset = 1'b1, ctl_enable = 1'b0, ctl_update = 1'b0;
    logic        ctl_busy;
    logic [7:0]  ctl_index;
    logic [31:0] param_addr = '0;
    logic [11:0] param_stride = '0, param_width = '0, param_height = '0;
    logic [7:0]  param_arlen = '0;
    logic [31:0] monitor_addr;
    logic [11:0] monitor_stride, monitor_width, monitor_height;
    logic [7:0]  monitor_arlen;
    logic [5:0]  m_axi4_arid;
    logic [31:0] m_axi4_araddr;
    logic [1:0]  m_axi4_arburst;
    logic [3:0]  m_axi4_arcache, m_axi4_arregion;
    logic [7:0]  m_axi4_arlen;
    logic [0:0]  m_axi4_arlock;
    logic [2:0]  m_axi4_arprot, m_axi4_arsize;
    logic [3:0]  m_axi4_arqos;
    logic        m_axi4_arvalid, m_axi4_arready = 1'b0;
    logic [5:0]  m_axi4_rid = '0;
    logic [1:0]  m_axi4_rresp = '0;
    logic [31:0] m_axi4_rdata = '0;
    logic        m_axi4_rlast = 1'b0, m_axi4_rvalid = 1'b0, m_axi4_rready;
    logic [0:0]  m_axi4s_tuser;
    logic        m_axi4s_tlast, m_axi4s_tvalid, m_axi4s_tready = 1'b0;
    logic [23:0] m_axi4s_tdata;

    vdma_axi4_to_axi4s_core dut (
        .aclk(aclk), .reset(reset),
        .ctl_enable(ctl_enable), .ctl_update(ctl_update),
        .ctl_busy(ctl_busy), .ctl_index(ctl_index),
        .param_addr(param_addr), .param_stride(param_stride),
        .param_width(param_width), .param_height(param_height),
        .param_arlen(param_arlen),
        .monitor_addr(monitor_addr), .monitor_stride(monitor_stride),
        .monitor_width(monitor_width), .monitor_height(monitor_height),
        .monitor_arlen(monitor_arlen),
        .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr),
        .m_axi4_arburst(m_axi4_arburst), .m_axi4_arcache(m_axi4_arcache),
        .m_axi4_arlen(m_axi4_arlen), .m_axi4_arlock(m_axi4_arlock),
        .m_axi4_arprot(m_axi4_arprot), .m_axi4_arqos(m_axi4_arqos),
        .m_axi4_arregion(m_axi4_arregion), .m_axi4_arsize(m_axi4_arsize),
        .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
        .m_axi4_rid(m_axi4_rid), .m_axi4_rresp(m_axi4_rresp),
        .m_axi4_rdata(m_axi4_rdata), .m_axi4_rlast(m_axi4_rlast),
        .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready),
        .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
        .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
        .m_axi4s_tready(m_axi4s_tready)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [11:0] stride;
        logic [11:0] w;
        logic [11:0] h;
        logic [7:0]  arlen;
    } cfg_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;
    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } px_t;

    ar_t         ar_log[$], exp_ar[$];
    px_t         st_log[$], exp_px[$];
    logic [31:0] beats[$];
    int          n_cmp = 0, n_fail = 0, rr_bad = 0;
    int          ar_pct = 100, r_pct = 100, t_pct = 100;
    bit          r_xfer = 1'b0;
    cfg_t        lat = '0;
    bit          first = 1'b1;
    logic [7:0]  idx_m = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ (a >> 7) ^ 32'h5A5A0000;
    endfunction

    // Memory slave and stream sink: inputs change at the falling edge,
    // handshakes that will complete on the next rising edge are logged.
    always @(negedge aclk) begin
        if (r_xfer && beats.size() > 0) void'(beats.pop_front());
        if (r_xfer) m_axi4_rvalid = 1'b0;
        r_xfer = 1'b0;
        m_axi4_arready = ($urandom_range(99) < ar_pct);
        m_axi4s_tready = ($urandom_range(99) < t_pct);
        if (!m_axi4_rvalid && beats.size() > 0 &&
            $urandom_range(99) < r_pct) begin
            m_axi4_rvalid = 1'b1;
            m_axi4_rdata  = mem(beats[0]);
            m_axi4_rid    = 6'($urandom);
            m_axi4_rresp  = 2'($urandom);
        end
        #1;
        if (reset) begin
            beats.delete();
            m_axi4_rvalid = 1'b0;
        end else begin
            if (m_axi4_rready !== m_axi4s_tready) rr_bad++;
            if (m_axi4_arvalid && m_axi4_arready) begin
                ar_log.push_back('{m_axi4_araddr, m_axi4_arlen});
                for (int i = 0; i <= int'(m_axi4_arlen); i++)
                    beats.push_back(m_axi4_araddr + 32'(i) * 4);
            end
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                st_log.push_back('{m_axi4s_tdata, m_axi4s_tuser[0],
                                   m_axi4s_tlast});
                r_xfer = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge aclk);
        #2;
    endtask

    task automatic clear_logs();
        ar_log.delete();
        st_log.delete();
        exp_ar.delete();
        exp_px.delete();
    endtask

    // Frame model: lines at addr+y*stride, bursts of up to arlen+1 pixels
    task automatic model_frame(input cfg_t c);
        logic [31:0] base;
        int n, x;
        for (int y = 0; y < int'(c.h); y++) begin
            base = c.addr + 32'(y) * 32'(c.stride);
            x = 0;
            while (x < int'(c.w)) begin
                n = int'(c.w) - x;
                if (n > int'(c.arlen) + 1) n = int'(c.arlen) + 1;
                exp_ar.push_back('{base + 32'(x) * 4, 8'(n - 1)});
                x += n;
            end
            for (int p = 0; p < int'(c.w); p++)
                exp_px.push_back('{mem(base + 32'(p) * 4) & 32'hFFFFFF,
                                   (p == 0 && y == 0),
                                   (p == int'(c.w) - 1)});
        end
    endtask

    task automatic set_params(input cfg_t c);
        param_addr   = c.addr;
        param_stride = c.stride;
        param_width  = c.w;
        param_height = c.h;
        param_arlen  = c.arlen;
    endtask

    task automatic wait_busy(input bit lvl, input int lim, output bit to);
        int k = 0;
        while (ctl_busy !== lvl && k < lim) begin
            step();
            k++;
        end
        to = (k >= lim);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ctl_enable = 1'b0;
        step();
        step();
        reset = 1'b0;
        first = 1'b1;
        idx_m = '0;
        lat = '0;
        clear_logs();
    endtask

    task automatic run_one(input cfg_t c, input bit upd, output bit to);
        bit t1, t2;
        set_params(c);
        ctl_update = upd;
        ctl_enable = 1'b1;
        if (upd || first) lat = c;
        first = 1'b0;
        idx_m = idx_m + 8'd1;
        model_frame(lat);
        step();
        wait_busy(1'b1, 50, t1);
        ctl_enable = 1'b0;
        wait_busy(1'b0, 40000, t2);
        to = t1 || t2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({m_axi4_arvalid, ctl_busy, ctl_index} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: arvalid=%b busy=%b index=%0d want 0/0/0",
                     m_axi4_arvalid, ctl_busy, ctl_index);
        end
        n_cmp++;
        if ({monitor_addr, monitor_stride, monitor_width, monitor_height,
             monitor_arlen} !== '0) begin
            n_fail++;
            $display("FAIL reset_monitor: addr=%h w=%0d h=%0d want 0",
                     monitor_addr, monitor_width, monitor_height);
        end
        n_cmp++;
        if ({m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_stream: tvalid/tuser/tlast=%b%b%b want 000",
                     m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast);
        end
        n_cmp++;
        if ({m_axi4_arburst, m_axi4_arcache, m_axi4_arsize, m_axi4_arid,
             m_axi4_arlock, m_axi4_arprot, m_axi4_arqos, m_axi4_arregion}
            !== {2'b01, 4'b0011, 3'd2, 6'd0, 1'b0, 3'd0, 4'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL ar_consts: burst=%b cache=%b size=%0d want 01/0011/2",
                     m_axi4_arburst, m_axi4_arcache, m_axi4_arsize);
        end
        reset = 1'b0;
        first = 1'b1;
        idx_m = '0;
        clear_logs();
    endtask

    task automatic test_burst_split();
        cfg_t c;
        bit to;
        c = '{32'h100, 12'd64, 12'd10, 12'd2, 8'd3};
        ar_pct = 60; r_pct = 70; t_pct = 80;
        clear_logs();
        run_one(c, 1'b1, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL split_timeout: frame stuck"); end
        n_cmp++;
        if (ar_log.size() != exp_ar.size()) begin
            n_fail++;
            $display("FAIL split_ar_count: got %0d want %0d",
                     ar_log.size(), exp_ar.size());
        end
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
            n_cmp++;
            if (ar_log[i] !== exp_ar[i]) begin
                n_fail++;
                $display("FAIL split_ar[%0d]: got %h/%0d want %h/%0d", i,
                         ar_log[i].addr, ar_log[i].len,
                         exp_ar[i].addr, exp_ar[i].len);
            end
        end
        n_cmp++;
        if (ar_log.size() < 4 || ar_log[2] !== ar_t'({32'h120, 8'd1}) ||
            ar_log[3] !== ar_t'({32'h140, 8'd3})) begin
            n_fail++;
            $display("FAIL split_tail: ar count %0d, want (120,1),(140,3)",
                     ar_log.size());
        end
        n_cmp++;
        if (st_log.size() != exp_px.size()) begin
            n_fail++;
            $display("FAIL split_px_count: got %0d want %0d",
                     st_log.size(), exp_px.size());
        end
        for (int i = 0; i < exp_px.size() && i < st_log.size(); i++) begin
            n_cmp++;
            if (st_log[i] !== exp_px[i]) begin
                n_fail++;
                $display("FAIL split_px[%0d]: got %h want %h", i,
                         st_log[i], exp_px[i]);
            end
        end
        n_cmp++;
        if (ctl_index !== idx_m || monitor_width !== 12'd10) begin
            n_fail++;
            $display("FAIL split_index: index=%0d width=%0d want %0d/10",
                     ctl_index, monitor_width, idx_m);
        end
    endtask

    task automatic test_line640();
        cfg_t c;
        bit to;
        int shown = 0;
        c = '{32'h0, 12'(4096), 12'd640, 12'd4, 8'd7};
        ar_pct = 70; r_pct = 95; t_pct = 90;
        clear_logs();
        run_one(c, 1'b1, to);
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL line640_timeout: frame stuck"); end
        n_cmp++;
        if (ar_log.size() != 320 || exp_ar.size() != 320) begin
            n_fail++;
            $display("FAIL line640_ar_count: got %0d want 320", ar_log.size());
        end
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
            n_cmp++;
            if (ar_log[i] !== exp_ar[i]) begin
                n_fail++;
                if (shown++ < 10)
                    $display("FAIL line640_ar[%0d]: got %h/%0d want %h/%0d", i,
                             ar_log[i].addr, ar_log[i].len,
                             exp_ar[i].addr, exp_ar[i].len);
            end
        end
        n_cmp++;
        if (st_log.size() != exp_px.size()) begin
            n_fail++;
            $display("FAIL line640_px_count: got %0d want %0d",
                     st_log.size(), exp_px.size());
        end
        for (int i = 0; i < exp_px.size() && i < st_log.size(); i++) begin
            n_cmp++;
            if (st_log[i] !== exp_px[i]) begin
                n_fail++;
                if (shown++ < 10)
                    $display("FAIL line640_px[%0d]: got %h want %h", i,
                             st_log[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_random();
        cfg_t c;
        bit to, upd;
        int shown = 0;
        clear_logs();
        for (int f = 0; f < 10; f++) begin
            c.addr   = ($urandom_range(2) == 0) ? 32'hFFFFFF00 + $urandom_range(255)
                                                : $urandom;
            c.stride = 12'($urandom);
            c.w      = 12'($urandom_range(40));
            c.h      = 12'($urandom_range(4));
            c.arlen  = 8'($urandom_range(15));
            if (f == 0) c.w = '0;
            if (f == 1) c.h = '0;
            upd = ($urandom_range(3) != 0);
            ar_pct = $urandom_range(100, 20);
            r_pct  = $urandom_range(100, 20);
            t_pct  = $urandom_range(100, 20);
            run_one(c, upd, to);
            n_cmp++;
            if (to || ctl_index !== idx_m) begin
                n_fail++;
                $display("FAIL rand_index f%0d: index=%0d want %0d timeout=%b",
                         f, ctl_index, idx_m, to);
            end
            n_cmp++;
            if ({monitor_addr, monitor_stride, monitor_width, monitor_height,
                 monitor_arlen} !== lat) begin
                n_fail++;
                $display("FAIL rand_monitor f%0d: got %h want %h", f,
                         {monitor_addr, monitor_stride, monitor_width,
                          monitor_height, monitor_arlen}, lat);
            end
        end
        n_cmp++;
        if (ar_log.size() != exp_ar.size()) begin
            n_fail++;
            $display("FAIL rand_ar_count: got %0d want %0d",
                     ar_log.size(), exp_ar.size());
        end
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
            n_cmp++;
            if (ar_log[i] !== exp_ar[i]) begin
                n_fail++;
                if (shown++ < 10)
                    $display("FAIL rand_ar[%0d]: got %h/%0d want %h/%0d", i,
                             ar_log[i].addr, ar_log[i].len,
                             exp_ar[i].addr, exp_ar[i].len);
            end
        end
        n_cmp++;
        if (st_log.size() != exp_px.size()) begin
            n_fail++;
            $display("FAIL rand_px_count: got %0d want %0d",
                     st_log.size(), exp_px.size());
        end
        for (int i = 0; i < exp_px.size() && i < st_log.size(); i++) begin
            n_cmp++;
            if (st_log[i] !== exp_px[i]) begin
                n_fail++;
                if (shown++ < 10)
                    $display("FAIL rand_px[%0d]: got %h want %h", i,
                             st_log[i], exp_px[i]);
            end
        end
        n_cmp++;
        if (rr_bad !== 0) begin
            n_fail++;
            $display("FAIL rready_track: %0d cycles with rready!=tready, want 0",
                     rr_bad);
        end
    endtask

    task automatic test_back_to_back();
        cfg_t c;
        bit to;
        logic [11:0] wseq[3];
        wseq[0] = 12'd12; wseq[1] = 12'd7; wseq[2] = 12'd5;
        do_reset();
        ar_pct = 80; r_pct = 80; t_pct = 70;
        c = '{32'h400, 12'd100, wseq[0], 12'd3, 8'd3};
        set_params(c);
        ctl_update = 1'b1;
        ctl_enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            c.w = wseq[f];
            model_frame(c);
            wait_busy(1'b1, 50, to);
            n_cmp++;
            if (to || ctl_index !== 8'(f + 1) || monitor_width !== wseq[f]) begin
                n_fail++;
                $display("FAIL b2b_start f%0d: index=%0d width=%0d want %0d/%0d",
                         f, ctl_index, monitor_width, f + 1, wseq[f]);
            end
            if (f < 2) param_width = wseq[f + 1];
            else ctl_enable = 1'b0;
            wait_busy(1'b0, 20000, to);
        end
        repeat (5) step();
        n_cmp++;
        if (ctl_busy !== 1'b0 || ctl_index !== 8'd3) begin
            n_fail++;
            $display("FAIL b2b_stop: busy=%b index=%0d want 0/3",
                     ctl_busy, ctl_index);
        end
        n_cmp++;
        if (ar_log !== exp_ar) begin
            n_fail++;
            $display("FAIL b2b_ar: got %0d bursts want %0d (or content differs)",
                     ar_log.size(), exp_ar.size());
        end
        n_cmp++;
        if (st_log !== exp_px) begin
            n_fail++;
            $display("FAIL b2b_px: got %0d pixels want %0d (or content differs)",
                     st_log.size(), exp_px.size());
        end
        first = 1'b0;
        idx_m = 8'd3;
        lat = c;
    endtask

    task automatic test_reset_mid();
        cfg_t c;
        bit to;
        int k = 0;
        do_reset();
        ar_pct = 90; r_pct = 90; t_pct = 90;
        c = '{32'h2000, 12'd256, 12'd32, 12'd4, 8'd7};
        set_params(c);
        ctl_update = 1'b1;
        ctl_enable = 1'b1;
        while (st_log.size() < 10 && k < 500) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= 500) begin
            n_fail++;
            $display("FAIL rmid_progress: %0d pixels want >=10", st_log.size());
        end
        reset = 1'b1;
        ctl_enable = 1'b0;
        step();
        n_cmp++;
        if ({m_axi4_arvalid, ctl_busy, ctl_index, monitor_addr} !== '0) begin
            n_fail++;
            $display("FAIL rmid_reset: arvalid=%b busy=%b index=%0d addr=%h want 0",
                     m_axi4_arvalid, ctl_busy, ctl_index, monitor_addr);
        end
        reset = 1'b0;
        first = 1'b1;
        idx_m = '0;
        clear_logs();
        c.addr = 32'h3000;
        run_one(c, 1'b0, to);
        n_cmp++;
        if (to || ar_log.size() == 0 || ar_log[0].addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL rmid_restart: first araddr=%h want 00003000 timeout=%b",
                     (ar_log.size() > 0) ? ar_log[0].addr : 32'hx, to);
        end
        n_cmp++;
        if (ar_log !== exp_ar || st_log !== exp_px || ctl_index !== 8'd1) begin
            n_fail++;
            $display("FAIL rmid_frame: ar %0d/%0d px %0d/%0d index=%0d want 1",
                     ar_log.size(), exp_ar.size(), st_log.size(),
                     exp_px.size(), ctl_index);
        end
    endtask

    initial begin
        test_reset();
        test_burst_split();
        test_line640();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vdma_axi4_to_axi4s_core.md
VDMA_AXI4_TO_AXI4S_CORE -- requirements
Module: vdma_axi4_to_axi4s_core

Interface
REQ-001 Parameters (name, default, meaning): AXI4_ID_WIDTH 6 ID width; AXI4_ADDR_WIDTH 32 address width; AXI4_DATA_SIZE 2 log2 of beat bytes, so rdata is 32 bits; AXI4_LEN_WIDTH 8 arlen width; AXI4_QOS_WIDTH 4 arqos width; AXI4S_USER_WIDTH 1 tuser width; AXI4S_DATA_WIDTH 24 pixel width; STRIDE_WIDTH 12 line stride width in bytes; INDEX_WIDTH 8 frame counter width; H_WIDTH 12 width field; V_WIDTH 12 height field.
REQ-002 One clock; reset is synchronous and active-high: aclk in 1 (all logic on rising edge); reset in 1 (synchronous, active-high).
REQ-003 Control ports: ctl_enable in 1 (run frames); ctl_update in 1 (reload params at frame start); ctl_busy out 1 (frame in progress); ctl_index out INDEX_WIDTH (frame counter).
REQ-004 Parameter inputs: param_addr in ADDR (frame base byte address); param_stride in STRIDE (line pitch, bytes); param_width in H (pixels per line); param_height in V (lines); param_arlen in LEN (burst length minus 1).
REQ-005 Monitor outputs: monitor_addr, monitor_stride, monitor_width, monitor_height, monitor_arlen, each out with the same width as its param_ input; they show the latched working copy.
REQ-006 AR channel outputs: m_axi4_arid, araddr, arburst[1:0], arcache[3:0], arlen, arlock[0:0], arprot[2:0], arqos, arregion[3:0], arsize[2:0], arvalid; input m_axi4_arready.
REQ-007 R channel inputs: m_axi4_rid, rresp[1:0], rdata (8<<AXI4_DATA_SIZE bits), rlast, rvalid; output m_axi4_rready.
REQ-008 Stream outputs: m_axi4s_tuser, tlast, tdata (AXI4S_DATA_WIDTH bits), tvalid; input m_axi4s_tready.

Function
REQ-009 Constant AR fields: arid=0, arburst=2'b01 (INCR), arcache=4'b0011, arlock=0, arprot=0, arqos=0, arregion=0, arsize=AXI4_DATA_SIZE.
REQ-010 States are IDLE and RUN; IDLE goes to RUN when ctl_enable=1; in that start cycle, all param_* are latched into the monitor_* registers if ctl_update=1 or this is the first frame after reset, otherwise the previous values are kept.
REQ-011 ctl_index increments by 1, wrapping modulo 2^INDEX_WIDTH, on each IDLE-to-RUN transition; ctl_busy=1 exactly while in RUN.
REQ-012 Address side: each line y (0..height-1) starts at addr + y*stride, using ADDR-width arithmetic that wraps; each line is split into bursts of (arlen+1) beats, one pixel per beat; araddr advances by (arlen+1)<<AXI4_DATA_SIZE within a line.
REQ-013 If width is not a multiple of (arlen+1), the last burst of the line uses arlen = remaining beats minus 1; no burst crosses a line boundary.
REQ-014 arvalid stays high with araddr and arlen stable until arready; the next request appears no earlier than the cycle after the handshake; outstanding requests are unlimited, and AR issuance does not wait on R.
REQ-015 Data side: tdata = rdata[AXI4S_DATA_WIDTH-1:0]; tvalid = rvalid; rready = tready (combinational passthrough, zero latency); rid, rresp and rlast are ignored.
REQ-016 Data-side x/y counters advance on each tvalid&tready transfer; tuser=1 only on pixel (0,0) of a frame; tlast=1 on x=width-1 of every line.
REQ-017 A frame completes when the last pixel (width-1, height-1) transfers and all AR requests have been issued; the core then goes to IDLE for one cycle and restarts at once if ctl_enable is still 1.
REQ-018 Deasserting ctl_enable mid-frame does not abort; the current frame completes, then the core stays in IDLE.
REQ-019 width=0 or height=0 when latched: the frame completes immediately, with no AR and no stream beats, and ctl_index still increments.

Reset
REQ-020 While reset=1: state IDLE, arvalid=0, ctl_busy=0, ctl_index=0, all monitor_* =0, x/y and address counters=0; first-frame flag set; tvalid and rready follow the passthrough rule (rvalid=0 from a reset slave gives tvalid=0).
REQ-021 Asserting reset mid-frame abandons the frame at once; the next frame restarts at line 0 and burst 0.

Verification
REQ-022 width=640, height=480, arlen=7, stride=4096 (truncated to 0 at STRIDE_WIDTH=12), addr=0 -> 80 bursts per line of arlen=7, araddr 0,32,...,2528 on every line; 640 beats per line with tlast on each 640th; tuser on first beat only.
REQ-023 width=10, arlen=3, height=2, stride=64, addr=0x100 -> AR sequence (0x100,3), (0x110,3), (0x120,1), (0x140,3), (0x150,3), (0x160,1).
REQ-024 tready toggled randomly -> rready tracks tready every cycle; no pixel is lost or duplicated; tlast and tuser positions are unchanged.
REQ-025 ctl_enable held at 1 over 3 frames, ctl_update=1, param_width changed mid-frame -> the change takes effect only on the next frame; ctl_index reads 1, 2, 3.
REQ-026 reset pulsed mid-line -> arvalid=0, ctl_busy=0 and ctl_index=0 the next cycle; the following frame starts at araddr=param_addr.
